// File: rtl/rvm_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rvm_mem_ctrl                                                    |
// | Purpose  : Core-side memory controller driving a synchronous single-port   |
// |            SRAM. It adds wait states and checks each request before use.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rvm_mem_ctrl #(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_c_en,
    input  logic [3:0]        mem_b_en,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              mem_error,
    output logic              sram_cs,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Window size is kept in 33 bits so BASE + size can never wrap.
    localparam logic [32:0] c_SIZE = 33'd4 << ADDR_W;
    localparam logic [3:0]  c_WAIT = 4'(WAIT_STATES);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_word;
    logic [31:0]       r_wdata;
    logic [3:0]        r_ben;
    logic [31:0]       r_hold;
    logic              r_error;
    logic              r_cs;
    logic [3:0]        r_we;
    logic [ADDR_W-1:0] r_saddr;
    logic [31:0]       r_swdata;

    logic [32:0]       w_offset;
    logic [ADDR_W-1:0] w_word;
    logic              w_align_ok;
    logic              w_range_ok;
    logic              w_ben_ok;
    logic              w_legal;
    logic              w_req;
    logic              w_go_direct;
    logic              w_go_wait;
    logic              w_resp_read;

    assign w_offset   = {1'b0, mem_addr} - {1'b0, BASE};
    assign w_word     = w_offset[ADDR_W+1:2];
    assign w_align_ok = (mem_addr[1:0] == 2'b00);
    assign w_range_ok = ~w_offset[32] & (w_offset < c_SIZE);

    always_comb begin
        w_ben_ok = 1'b0;
        case (mem_b_en)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: w_ben_ok = 1'b1;
            default:                            w_ben_ok = 1'b0;
        endcase
    end

    assign w_legal     = w_align_ok & w_range_ok & w_ben_ok;
    assign w_req       = (r_state == S_IDLE) & mem_c_en;
    assign w_go_direct = w_req & w_legal & (WAIT_STATES == 0);
    assign w_go_wait   = (r_state == S_WAIT) & (r_cnt == 4'd1);
    assign w_resp_read = (r_state == S_RESP) & (r_ben == 4'b0000);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_word   <= '0;
            r_wdata  <= 32'd0;
            r_ben    <= 4'd0;
            r_hold   <= 32'd0;
            r_error  <= 1'b0;
            r_cs     <= 1'b0;
            r_we     <= 4'd0;
            r_saddr  <= '0;
            r_swdata <= 32'd0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_c_en) begin
                        r_word  <= w_word;
                        r_wdata <= mem_wdata;
                        r_ben   <= mem_b_en;
                        if (!w_legal) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: r_state <= S_RESP;
                S_RESP: begin
                    if (r_ben == 4'b0000) begin
                        r_hold <= sram_rdata;
                    end
                    r_state <= S_IDLE;
                end
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // The strobe is registered so it is high exactly in ACCESS.
            if (w_go_direct) begin
                r_cs     <= 1'b1;
                r_we     <= mem_b_en;
                r_saddr  <= w_word;
                r_swdata <= mem_wdata;
            end else if (w_go_wait) begin
                r_cs     <= 1'b1;
                r_we     <= r_ben;
                r_saddr  <= r_word;
                r_swdata <= r_wdata;
            end else if (r_state == S_ACCESS) begin
                r_cs <= 1'b0;
                r_we <= 4'd0;
            end
        end
    end

    assign mem_stall  = w_req | (r_state == S_WAIT) | (r_state == S_ACCESS);
    assign mem_error  = r_error;
    assign mem_rdata  = w_resp_read ? sram_rdata : r_hold;
    assign sram_cs    = r_cs;
    assign sram_we    = r_we;
    assign sram_addr  = r_saddr;
    assign sram_wdata = r_swdata;

endmodule
`default_nettype wire

// File: tb/tb_rvm_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rvm_mem_ctrl                                                 |
// | Purpose  : Bench for rvm_mem_ctrl with SRAM models and a word-level model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_rvm_mem_ctrl;

    localparam int          AW     = 12;
    localparam int          DEPTH  = 1 << AW;
    localparam int          WS_A   = 1;
    localparam logic [31:0] BASE_A = 32'h0000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic mem_init = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_addr = 0, a_wdata = 0, a_rdata, a_swdata, a_srdata;
    logic [3:0]  a_ben = 0, a_we;
    logic        a_c_en = 0, a_stall, a_error, a_cs;
    logic [AW-1:0] a_saddr;

    logic [31:0] b_addr = 0, b_wdata = 0, b_rdata, b_swdata, b_srdata;
    logic [3:0]  b_ben = 0, b_we;
    logic        b_c_en = 0, b_stall, b_error, b_cs;
    logic [AW-1:0] b_saddr;

    rvm_mem_ctrl #(.ADDR_W(AW), .BASE(BASE_A), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_c_en(a_c_en), .mem_b_en(a_ben),
        .mem_rdata(a_rdata), .mem_stall(a_stall), .mem_error(a_error),
        .sram_cs(a_cs), .sram_we(a_we), .sram_addr(a_saddr),
        .sram_wdata(a_swdata), .sram_rdata(a_srdata)
    );

    rvm_mem_ctrl #(.ADDR_W(AW), .BASE(32'h0), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_c_en(b_c_en), .mem_b_en(b_ben),
        .mem_rdata(b_rdata), .mem_stall(b_stall), .mem_error(b_error),
        .sram_cs(b_cs), .sram_we(b_we), .sram_addr(b_saddr),
        .sram_wdata(b_swdata), .sram_rdata(b_srdata)
    );

    function automatic logic [31:0] init_word(input int i, input logic [31:0] salt);
        return (32'(i) * 32'h9E37_79B1) ^ salt;
    endfunction

    // Behavioural SRAMs: read data appears the cycle after the strobe.
    logic [31:0] sram_a [DEPTH];
    logic [31:0] sram_b [DEPTH];
    logic [31:0] wa, wb;
    int cs_cnt_a = 0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++)
                sram_a[i] <= (i == 5) ? 32'hDEADBEEF : init_word(i, 32'h5A00_00C3);
        end else if (a_cs) begin
            wa = sram_a[a_saddr];
            for (int b = 0; b < 4; b++)
                if (a_we[b]) wa[8*b +: 8] = a_swdata[8*b +: 8];
            sram_a[a_saddr] <= wa;
            a_srdata <= sram_a[a_saddr];
            cs_cnt_a <= cs_cnt_a + 1;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++)
                sram_b[i] <= init_word(i, 32'h3C00_0071);
        end else if (b_cs) begin
            wb = sram_b[b_saddr];
            for (int b = 0; b < 4; b++)
                if (b_we[b]) wb[8*b +: 8] = b_swdata[8*b +: 8];
            sram_b[b_saddr] <= wb;
            b_srdata <= sram_b[b_saddr];
        end
    end

    // Reference model: word arrays plus the value the core last read.
    logic [31:0] ref_a [DEPTH];
    logic [31:0] ref_b [DEPTH];
    logic [31:0] hold_a = 0, hold_b = 0;
    int n_cmp = 0, n_bad = 0;

    function automatic bit ref_legal(input logic [31:0] addr, input logic [3:0] ben);
        longint unsigned a, lo, hi;
        a  = longint'(addr);
        lo = longint'(BASE_A);
        hi = lo + 4 * DEPTH;
        return (a % 4 == 0) && (a >= lo) && (a < hi) &&
               (ben inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ben);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ben[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic txn_a(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] ben, input bit scramble);
        bit legal, done;
        int k, cs_seen, idx, exp_lat;
        logic [31:0] exp_rd;
        logic [AW-1:0] exp_sa;
        legal   = ref_legal(addr, ben);
        idx     = int'((addr - BASE_A) >> 2) & (DEPTH - 1);
        exp_sa  = idx[AW-1:0];
        exp_lat = legal ? WS_A + 2 : 1;
        exp_rd  = (legal && ben == 4'h0) ? ref_a[idx] : hold_a;
        @(negedge clk);
        a_addr = addr; a_wdata = wdata; a_ben = ben; a_c_en = 1'b1;
        #1;
        n_cmp++;
        if (a_stall !== 1'b1) begin
            n_bad++; $display("FAIL req_stall addr=%h: got %b expected 1", addr, a_stall);
        end
        k = 0; cs_seen = 0; done = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (a_cs === 1'b1) begin
                cs_seen++;
                n_cmp++;
                if (k != WS_A + 1 || a_saddr !== exp_sa || a_we !== ben ||
                    (ben != 4'h0 && a_swdata !== wdata)) begin
                    n_bad++;
                    $display("FAIL strobe addr=%h: got cyc=%0d sa=%h we=%b wd=%h expected cyc=%0d sa=%h we=%b wd=%h",
                             addr, k, a_saddr, a_we, a_swdata, WS_A + 1, exp_sa, ben, wdata);
                end
            end
            if (a_stall === 1'b0) begin
                done = 1;
                n_cmp++;
                if (k != exp_lat) begin
                    n_bad++; $display("FAIL latency addr=%h: got %0d expected %0d", addr, k, exp_lat);
                end
                n_cmp++;
                if (a_error !== !legal) begin
                    n_bad++; $display("FAIL error_flag addr=%h ben=%b: got %b expected %b", addr, ben, a_error, !legal);
                end
                n_cmp++;
                if (a_rdata !== exp_rd) begin
                    n_bad++; $display("FAIL rdata addr=%h: got %h expected %h", addr, a_rdata, exp_rd);
                end
            end else begin
                n_cmp++;
                if (a_error !== 1'b0) begin
                    n_bad++; $display("FAIL early_error addr=%h cyc=%0d: got %b expected 0", addr, k, a_error);
                end
            end
            if (scramble && k == 1 && !done) begin
                a_c_en = 1'($urandom_range(0, 1)); a_addr = $urandom;
                a_wdata = $urandom; a_ben = 4'($urandom);
            end
        end
        a_c_en = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout addr=%h: got no response expected one within 40 cycles", addr);
        end
        n_cmp++;
        if (cs_seen != (legal ? 1 : 0)) begin
            n_bad++; $display("FAIL strobe_count addr=%h: got %0d expected %0d", addr, cs_seen, legal ? 1 : 0);
        end
        if (legal && ben != 4'h0) ref_a[idx] = merge(ref_a[idx], wdata, ben);
        if (legal && ben == 4'h0) hold_a = exp_rd;
        @(negedge clk);
        n_cmp++;
        if (a_stall !== 1'b0 || a_error !== 1'b0 || a_rdata !== hold_a) begin
            n_bad++;
            $display("FAIL idle_after addr=%h: got stall=%b err=%b rdata=%h expected 0 0 %h",
                     addr, a_stall, a_error, a_rdata, hold_a);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_rdata, a_stall, a_error, a_cs, a_we, a_saddr, a_swdata} !== '0) begin
            n_bad++; $display("FAIL reset_a: got rdata=%h cs=%b we=%b expected all zero", a_rdata, a_cs, a_we);
        end
        n_cmp++;
        if ({b_rdata, b_stall, b_error, b_cs, b_we, b_saddr, b_swdata} !== '0) begin
            n_bad++; $display("FAIL reset_b: got rdata=%h cs=%b we=%b expected all zero", b_rdata, b_cs, b_we);
        end
        mem_init = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_rdata, a_stall, a_error, a_cs} !== '0) begin
            n_bad++; $display("FAIL post_reset: got rdata=%h stall=%b expected 0 0", a_rdata, a_stall);
        end
    endtask

    task automatic test_read_wait();
        txn_a(32'h14, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_errors();
        txn_a(32'h22, 32'h0, 4'h0, 1'b0);
        txn_a(32'h4000, 32'h0, 4'h0, 1'b0);
        txn_a(32'h3FFC, 32'h0, 4'h0, 1'b0);
        txn_a(32'h10, 32'h1234_5678, 4'b0101, 1'b0);
        txn_a(32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0);
        txn_a(32'h3FFE, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_byte_write();
        txn_a(32'h20, 32'h00AB_0000, 4'b0100, 1'b0);
        txn_a(32'h20, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] legal_ben [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        logic [31:0] addr;
        logic [3:0] ben;
        int r, rb;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            addr = (r < 6) ? 32'($urandom_range(0, 15)) * 4 : 32'($urandom_range(0, DEPTH - 1)) * 4;
            if (r == 0) addr = addr | 32'($urandom_range(1, 3));
            if (r == 1) addr = 32'h4000 + 32'($urandom_range(0, 1000)) * 4;
            rb = $urandom_range(0, 4);
            if (rb == 0)      ben = 4'($urandom);
            else if (rb < 3)  ben = 4'h0;
            else              ben = legal_ben[$urandom_range(0, 7)];
            txn_a(addr, $urandom, ben, $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic b2b(input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] e1,
                       input logic [31:0] a2, input logic [31:0] w2, input logic [3:0] e2);
        int k, got;
        logic [31:0] exp1, exp2;
        exp1 = (e1 == 4'h0) ? ref_b[a1 >> 2] : hold_b;
        if (e1 == 4'h0) hold_b = exp1;
        else ref_b[a1 >> 2] = merge(ref_b[a1 >> 2], w1, e1);
        exp2 = (e2 == 4'h0) ? ref_b[a2 >> 2] : hold_b;
        if (e2 == 4'h0) hold_b = exp2;
        else ref_b[a2 >> 2] = merge(ref_b[a2 >> 2], w2, e2);
        @(negedge clk);
        b_addr = a1; b_wdata = w1; b_ben = e1; b_c_en = 1'b1;
        k = 0; got = 0;
        while (got < 2 && k < 30) begin
            @(negedge clk);
            k++;
            if (b_cs === 1'b1) begin
                n_cmp++;
                if (b_stall !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_access_stall cyc=%0d: got %b expected 1", k, b_stall);
                end
            end
            if (b_stall === 1'b0) begin
                got++;
                n_cmp++;
                if (k != (got == 1 ? 2 : 5) || b_rdata !== (got == 1 ? exp1 : exp2)) begin
                    n_bad++;
                    $display("FAIL b2b_resp%0d: got cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                             got, k, b_rdata, got == 1 ? 2 : 5, got == 1 ? exp1 : exp2);
                end
                if (got == 1) begin
                    b_addr = a2; b_wdata = w2; b_ben = e2;
                end else begin
                    b_c_en = 1'b0;
                end
            end
        end
        b_c_en = 1'b0;
        if (got < 2) begin
            n_cmp++; n_bad++;
            $display("FAIL b2b_timeout: got %0d responses expected 2", got);
        end
    endtask

    task automatic test_back_to_back();
        b2b(32'h4, 32'h0, 4'h0, 32'h8, 32'h0, 4'h0);
        b2b(32'hC, 32'h1357_9BDF, 4'b0011, 32'hC, 32'h0, 4'h0);
        b2b(32'h10, 32'hFFEE_DDCC, 4'b1111, 32'h4, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid();
        int cs0;
        cs0 = cs_cnt_a;
        @(negedge clk);
        a_addr = 32'h24; a_wdata = 32'hCAFE_F00D; a_ben = 4'hF; a_c_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_stall !== 1'b1) begin
            n_bad++; $display("FAIL wait_stall: got %b expected 1", a_stall);
        end
        resetn = 1'b0;
        a_c_en = 1'b0;
        #1;
        n_cmp++;
        if ({a_rdata, a_stall, a_error, a_cs, a_we, a_saddr, a_swdata} !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got rdata=%h cs=%b sa=%h expected all zero", a_rdata, a_cs, a_saddr);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        hold_a = 32'h0;
        hold_b = 32'h0;
        #1;
        n_cmp++;
        if ({a_rdata, a_stall, a_error, a_cs, a_we, a_saddr, a_swdata} !== '0) begin
            n_bad++; $display("FAIL release_outputs: got rdata=%h cs=%b sa=%h expected all zero", a_rdata, a_cs, a_saddr);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (cs_cnt_a != cs0) begin
            n_bad++; $display("FAIL reset_no_strobe: got %0d strobes expected 0", cs_cnt_a - cs0);
        end
        txn_a(32'h24, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_a[i] = (i == 5) ? 32'hDEADBEEF : init_word(i, 32'h5A00_00C3);
            ref_b[i] = init_word(i, 32'h3C00_0071);
        end
        mem_init = 1'b1;
        test_reset();
        test_read_wait();
        test_errors();
        test_byte_write();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvm_mem_ctrl.md
Name: rvm_mem_ctrl

Overview:
- Memory controller directly downstream of the core's single-port memory interface.
- Accepts word-aligned read/write requests from the core and executes them on a synchronous single-port SRAM.
- Inserts a configurable number of wait states and generates the `mem_stall` and `mem_error` responses the core consumes.
- Checks alignment, range and byte-enable legality before any SRAM access is made.

Parameters:
- ADDR_W, 12, SRAM word-address width; capacity is 2^ADDR_W words.
- BASE, 32'h0000_0000, byte address of SRAM word 0; must be a multiple of 4*2^ADDR_W.
- WAIT_STATES, 1, extra stall cycles inserted before the SRAM strobe; range 0..15.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- mem_addr  in  32  core byte address.
- mem_wdata  in  32  core write data.
- mem_c_en  in  1  core request.
- mem_b_en  in  4  byte enables; 0000 means read, non-zero means write of the enabled bytes.
- mem_rdata  out  32  read data to core.
- mem_stall  out  1  core must hold its request while this is high.
- mem_error  out  1  one-cycle error response.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid in the cycle after `sram_cs`.

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, wait counter 0, read-data hold register 0.
- States: IDLE, WAIT, ACCESS, RESP, ERR.
- `mem_stall` (combinational) = (IDLE & `mem_c_en`) | WAIT | ACCESS. It is 0 in RESP and ERR.
- IDLE:
  - `mem_c_en` is sampled only in IDLE.
  - On a request, latch addr, wdata and b_en.
  - A request is illegal if any of these hold:
    - `mem_addr[1:0]` != 0;
    - `mem_addr` < BASE;
    - `mem_addr` >= BASE + 4*2^ADDR_W;
    - `mem_b_en` is not one of 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Illegal request -> ERR.
  - Legal request -> WAIT with counter = WAIT_STATES, or straight to ACCESS if WAIT_STATES = 0.
- WAIT: counter decrements each cycle; at 1 -> ACCESS.
- ACCESS:
  - `sram_cs` = 1, `sram_we` = latched b_en.
  - `sram_addr` = (latched addr - BASE) >> 2.
  - `sram_wdata` = latched wdata.
  - Then -> RESP.
- RESP:
  - For a read, `mem_rdata` = `sram_rdata` combinationally, and the hold register loads `sram_rdata` at the end of the cycle.
  - For a write, `mem_rdata` = hold register (unchanged).
  - Always -> IDLE.
- ERR: `mem_error` = 1 for exactly one cycle; no SRAM strobe issued; `mem_rdata` unchanged; -> IDLE.
- Outside RESP, `mem_rdata` = hold register.
- Latency from request cycle T:
  - legal response (stall low) at T + WAIT_STATES + 2;
  - error response at T + 1.
- Back-to-back requests: RESP/ERR always returns to IDLE, so the earliest next request is sampled the cycle after the response.
- SRAM outputs: `sram_cs`/`sram_we` are 0 in every state except ACCESS. `sram_addr`/`sram_wdata` hold their last values when idle.
- Protocol violation: if `mem_c_en` drops or inputs change during WAIT/ACCESS, the latched transaction completes unchanged.
- Reset asserted mid-transaction: return immediately to IDLE with all outputs 0; no partial SRAM write occurs after reset assertion.
- Address arithmetic: unsigned 32-bit; the range check must not wrap (BASE + size computed in 33 bits).

Test Plan:
- Read, WAIT_STATES=1, BASE=0: SRAM word 5 = 32'hDEADBEEF; `mem_c_en`=1, addr=32'h14, b_en=0 at cycle T -> stall high T..T+2, `sram_cs` at T+2 with `sram_addr`=5, `mem_rdata`=32'hDEADBEEF and stall=0 at T+3.
- Byte write: addr=32'h20, b_en=4'b0100, wdata=32'h00AB0000 -> exactly one `sram_cs` cycle with `sram_we`=4'b0100, `sram_addr`=8; a readback of word 8 returns byte 2 = 8'hAB with the other bytes unchanged.
- Misaligned access: addr=32'h22, b_en=0 -> `mem_error`=1, stall=0 at T+1; `sram_cs` never asserted; `mem_rdata` keeps its prior value.
- Out-of-range and illegal enables (ADDR_W=12): addr=32'h4000 -> error; addr=32'h3FFC -> legal, `sram_addr`=12'hFFF; b_en=4'b0101 -> error.
- WAIT_STATES=0 back-to-back reads of words 1 and 2 -> responses at T+2 and T+5 with the correct data; stall never low while in ACCESS.
- Reset pulsed during WAIT of a write -> `sram_cs`=0 throughout; after release all outputs are 0 and the next read returns the old SRAM contents.
